rr_lease_arbiter: RTL and testbench

Four-requester round-robin arbiter for a single shared resource. It grants exclusive tenure to one requester at a time and holds the grant until that requester releases. An optional tenure timeout force-revokes a grant that is held too long. It sits in front of the shared resource and drives the per-requester grant lines in the same request/grant style as the existing arbitration benchmarks.

---
 rtl/rr_lease_arbiter.sv | 143 ++++++++++++++
 tb/tb_rr_lease_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_lease_arbiter.sv
// Four-requester round-robin lease arbiter: grant held until release, one dead cycle between grants.
// Optional tenure timeout with force-revoke and expired mask is compiled in by defining LEASE_TIMEOUT_EN.
module rr_lease_arbiter #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       revoke
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e     state_q;
    logic [1:0] ptr_q;
    logic [3:0] grant_q;
    logic [1:0] grant_id_q;
    logic       busy_q;

    logic [3:0] elig_s;
    logic [7:0] elig_dbl_s;
    logic [3:0] elig_rot_s;
    logic [1:0] off_s;
    logic [1:0] sel_s;
    logic       any_elig_s;

`ifdef LEASE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       xm_q;
    logic             revoke_q;

    assign elig_s = req & ~xm_q;
    assign revoke = revoke_q;
`else
    logic [31:0] cfg_unused_s;

    assign cfg_unused_s = 32'(HOLD_MAX + CNT_W);
    assign elig_s       = req;
    assign revoke       = 1'b0;
`endif

    // Rotate eligibility so bit 0 is the requester at ptr, then pick the lowest set bit.
    assign elig_dbl_s = {elig_s, elig_s};
    assign elig_rot_s = elig_dbl_s[ptr_q +: 4];
    assign any_elig_s = |elig_s;
    assign sel_s      = ptr_q + off_s;

    // Priority encoder over the rotated eligibility vector.
    always_comb begin
        off_s = 2'd0;
        casez (elig_rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
    end

    // Lease FSM with registered grant, grant_id, busy and revoke.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 2'd0;
            grant_q    <= 4'b0000;
            grant_id_q <= 2'd0;
            busy_q     <= 1'b0;
`ifdef LEASE_TIMEOUT_EN
            cnt_q      <= '0;
            xm_q       <= 4'b0000;
            revoke_q   <= 1'b0;
`endif
        end else begin
`ifdef LEASE_TIMEOUT_EN
            revoke_q <= 1'b0;
            // A requester seen low is forgiven; a timeout below re-marks its own bit.
            xm_q     <= xm_q & req;
`endif
            case (state_q)
                ST_IDLE, ST_GAP: begin
                    if (any_elig_s) begin
                        state_q    <= ST_GRANT;
                        grant_q    <= 4'b0001 << sel_s;
                        grant_id_q <= sel_s;
                        ptr_q      <= sel_s + 2'd1;
                        busy_q     <= 1'b1;
`ifdef LEASE_TIMEOUT_EN
                        cnt_q      <= '0;
`endif
                    end else begin
                        state_q    <= ST_IDLE;
                        grant_q    <= 4'b0000;
                        grant_id_q <= 2'd0;
                        busy_q     <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (!req[grant_id_q]) begin
                        state_q    <= ST_GAP;
                        grant_q    <= 4'b0000;
                        grant_id_q <= 2'd0;
                        busy_q     <= 1'b0;
`ifdef LEASE_TIMEOUT_EN
                    end else if (cnt_q == CNT_LAST) begin
                        state_q          <= ST_GAP;
                        grant_q          <= 4'b0000;
                        grant_id_q       <= 2'd0;
                        busy_q           <= 1'b0;
                        revoke_q         <= 1'b1;
                        xm_q[grant_id_q] <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
`else
                    end else begin
                        state_q <= ST_GRANT;
`endif
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    grant_q    <= 4'b0000;
                    grant_id_q <= 2'd0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rr_lease_arbiter.sv
// Self-checking bench for rr_lease_arbiter: directed test-plan scenarios plus sticky random requests,
// all compared cycle by cycle against a lease-level reference model (honours LEASE_TIMEOUT_EN).
module tb_rr_lease_arbiter;

    localparam int HOLD_MAX = 15;
    localparam int CNT_W    = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       revoke;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the resource, for how long, next-in-line pointer, expired flags.
    int m_owner;
    int m_ptr;
    int m_ten;
    bit m_rev;
    bit m_xm [4];

    always #5 clk = ~clk;

    rr_lease_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .revoke   (revoke)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_ten   = 0;
        m_rev   = 1'b0;
        for (int i = 0; i < 4; i++) m_xm[i] = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r);
        m_rev = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1;
`ifdef LEASE_TIMEOUT_EN
            end else if (m_ten == HOLD_MAX - 1) begin
                m_rev         = 1'b1;
                m_xm[m_owner] = 1'b1;
                m_owner       = -1;
`endif
            end else begin
                m_ten++;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (r[idx] && !m_xm[idx]) begin
                    m_owner = idx;
                    m_ten   = 0;
                    m_ptr   = (idx + 1) % 4;
                    break;
                end
            end
        end
        for (int i = 0; i < 4; i++) if (!r[i]) m_xm[i] = 1'b0;
    endtask

    task automatic check_outs(input string tag);
        logic [3:0] eg;
        logic [1:0] eid;
        eg  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        eid = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        chk({tag, ".grant"},    32'(grant),    32'(eg));
        chk({tag, ".grant_id"}, 32'(grant_id), 32'(eid));
        chk({tag, ".busy"},     32'(busy),     32'(m_owner >= 0));
        chk({tag, ".revoke"},   32'(revoke),   32'(m_rev));
    endtask

    task automatic cycle(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
        check_outs("cyc");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b0000;
        model_reset();
        #1;
        check_outs("rst");
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waits;
        int hi;
        int revs;
        logic [3:0] r;

        reset = 1'b0;
        req   = 4'b0000;
        model_reset();
        #1;
        check_outs("por");
        #20;
        reset = 1'b1;

        // Single request then release.
        do_reset();
        cycle(4'b0100);
        chk("single.grant", 32'(grant), 32'h4);
        chk("single.id", 32'(grant_id), 32'd2);
        chk("single.busy", 32'(busy), 32'd1);
        cycle(4'b0000);
        chk("single.release", 32'(grant), 32'h0);
        cycle(4'b0000);

        // Round-robin rotation with three-cycle tenures and one dead cycle between grants.
        do_reset();
        for (int g = 0; g < 5; g++) begin
            int cur;
            waits = 0;
            while (grant == 4'b0000 && waits < 8) begin
                cycle(4'b1111);
                waits++;
            end
            chk("rot.order", 32'(grant_id), 32'(g % 4));
            if (g > 0) chk("rot.gap", 32'(waits), 32'd1);
            cur = int'(grant_id);
            cycle(4'b1111);
            cycle(4'b1111);
            cycle(4'b1111 & ~(4'b0001 << cur));
            chk("rot.dead", 32'(grant), 32'h0);
        end

`ifdef LEASE_TIMEOUT_EN
        // Timeout: tenure exactly HOLD_MAX, one revoke, no regrant until req drops.
        do_reset();
        hi   = 0;
        revs = 0;
        for (int c = 0; c < HOLD_MAX + 8; c++) begin
            cycle(4'b0001);
            if (grant[0]) hi++;
            if (revoke) revs++;
        end
        chk("to.tenure", 32'(hi), 32'(HOLD_MAX));
        chk("to.revokes", 32'(revs), 32'd1);
        cycle(4'b0000);
        cycle(4'b0001);
        chk("to.regrant", 32'(grant), 32'h1);

        // Release coincident with timeout condition counts as release.
        do_reset();
        cycle(4'b0011);
        for (int c = 0; c < HOLD_MAX - 1; c++) cycle(4'b0001);
        cycle(4'b0010);
        chk("coinc.revoke", 32'(revoke), 32'd0);
        chk("coinc.grant", 32'(grant), 32'h0);
        cycle(4'b0010);
        chk("coinc.next", 32'(grant), 32'h2);
`else
        // Without timeout, tenure is unbounded.
        do_reset();
        hi   = 0;
        revs = 0;
        for (int c = 0; c < 100; c++) begin
            cycle(4'b0001);
            if (grant[0]) hi++;
            if (revoke) revs++;
        end
        chk("notimeout.held", 32'(hi), 32'd100);
        chk("notimeout.revoke", 32'(revs), 32'd0);
`endif

        // Asynchronous reset mid-grant, ptr restarts at 0.
        do_reset();
        cycle(4'b1000);
        cycle(4'b1000);
        chk("areset.pre", 32'(grant), 32'h8);
        @(negedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("areset.grant", 32'(grant), 32'h0);
        chk("areset.busy", 32'(busy), 32'd0);
        chk("areset.revoke", 32'(revoke), 32'd0);
        @(negedge clk);
        req = 4'b1001;
        #2;
        reset = 1'b1;
        cycle(4'b1001);
        chk("areset.first", 32'(grant), 32'h1);

        // Sticky random requests against the model.
        do_reset();
        r = 4'b0000;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 40) == 0) r = 4'($urandom);
            cycle(r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
